// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared MIPS mult/div opcodes, default latencies and sequencer state encodings
package md_ctrl_pkg;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL = 2'd1;
  localparam logic [1:0] DIV = 2'd2;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit {HI,LO} result for mult/multu/div/divu
module md_calc
  import md_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);
  logic [31:0] bd, sq, sr, uq, ur;
  logic [63:0] ps, pu;
  always_comb begin
    bd = b == 32'd0 ? 32'd1 : b;
    ps = 64'($signed(a)) * 64'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    sq = $signed(a) / $signed(bd);
    sr = $signed(a) % $signed(bd);
    uq = a / bd;
    ur = a % bd;
    res = op == OP_MULT ? ps : op == OP_MULTU ? pu : op == OP_DIV ? {sr, sq} : {ur, uq};
  end
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle mult/div sequencer owning HI/LO with pipeline stall request
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] WD,
  input  logic        MdUse_D,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
  logic [1:0] state, op_r;
  logic [31:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic [63:0] res;
  logic done;
  md_calc u_calc (.op(op_r), .a(a_r), .b(b_r), .res(res));
  assign Busy = state != IDLE;
  assign Stall = MdUse_D & (Busy | Start);
  assign done = (state == MUL && cnt == CW'(MUL_LAT)) || (state == DIV && cnt == CW'(DIV_LAT));
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt <= '0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      HI <= '0;
      LO <= '0;
    end else if (!Busy) begin
      if (Start) begin
        state <= Op[1] ? DIV : MUL;
        cnt <= CW'(1);
        op_r <= Op;
        a_r <= A;
        b_r <= B;
      end else begin
        if (MtHi) HI <= WD;
        if (MtLo) LO <= WD;
      end
    end else if (done) begin
      state <= IDLE;
      cnt <= '0;
      if (state == MUL || b_r != 32'd0) {HI, LO} <= res;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed vector table plus corner-case sequences for md_ctrl
module tb_md_ctrl;
  logic Clk = 0, Reset = 0, Start = 0, MtHi = 0, MtLo = 0, MdUse_D = 0;
  logic [1:0] Op = 0;
  logic [31:0] A = 0, B = 0, WD = 0;
  logic Busy, Stall;
  logic [31:0] HI, LO;
  int total = 0, bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t v[10];

  md_ctrl dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
               .MtHi(MtHi), .MtLo(MtLo), .WD(WD), .MdUse_D(MdUse_D),
               .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO));

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge Clk);
    Start = 1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1 Start = 0; A = ~a; B = b ^ 32'h5A5A_0001; Op = ~op;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (!Busy) break;
      n++;
    end
    chk({name, "_busy"}, n, op[1] ? 32'd10 : 32'd5);
    chk({name, "_hi"}, HI, ehi);
    chk({name, "_lo"}, LO, elo);
  endtask

  initial begin
    v[0] = '{2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
    v[1] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14};
    v[2] = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[4] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    v[5] = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    v[6] = '{2'b11, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC};
    v[7] = '{2'b00, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000};
    v[8] = '{2'b01, 32'h80000000, 32'd2, 32'h00000001, 32'h00000000};
    v[9] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};

    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_stall", 32'(Stall), 0);
    Reset = 1;

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].hi, v[i].lo);

    @(negedge Clk);
    MdUse_D = 1; Start = 1; Op = 2'b00; A = 32'd2; B = 32'd2;
    #1 chk("stall_start", 32'(Stall), 1);
    @(posedge Clk);
    #1 Start = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk($sformatf("stall_busy%0d", i), {30'd0, Busy, Stall}, 32'd3);
    end
    @(negedge Clk);
    chk("stall_end", {30'd0, Busy, Stall}, 32'd0);
    MdUse_D = 0;

    MtHi = 1; WD = 32'd5;
    @(negedge Clk);
    MtHi = 0; MtLo = 1; WD = 32'd9;
    @(negedge Clk);
    MtLo = 0;
    chk("mt_busy", 32'(Busy), 0);
    chk("mt_hi", HI, 5);
    chk("mt_lo", LO, 9);
    run_op("div0", 2'b10, 32'd1234, 32'd0, 32'd5, 32'd9);

    Start = 1; Op = 2'b00; A = 32'd3; B = 32'd4;
    @(posedge Clk);
    #1 Start = 0;
    @(negedge Clk);
    chk("ign_busy1", 32'(Busy), 1);
    MtLo = 1; WD = 32'hDEADBEEF; Start = 1; Op = 2'b11; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    chk("ign_busy2", 32'(Busy), 1);
    chk("ign_lo_mid", LO, 9);
    MtLo = 0; Start = 0;
    for (int i = 3; i <= 5; i++) begin
      @(negedge Clk);
      chk($sformatf("ign_busy%0d", i), 32'(Busy), 1);
    end
    @(negedge Clk);
    chk("ign_end", 32'(Busy), 0);
    chk("ign_hi", HI, 0);
    chk("ign_lo", LO, 12);
    @(negedge Clk);
    chk("ign_norestart", 32'(Busy), 0);

    Start = 1; MtHi = 1; WD = 32'hAAAA; Op = 2'b00; A = 32'd2; B = 32'd3;
    @(posedge Clk);
    #1 Start = 0; MtHi = 0;
    @(negedge Clk);
    chk("prio_busy", 32'(Busy), 1);
    chk("prio_hi_mid", HI, 0);
    for (int i = 0; i < 50 && Busy; i++) @(negedge Clk);
    chk("prio_lo", LO, 6);

    MtHi = 1; WD = 32'h1111;
    @(negedge Clk);
    MtHi = 0;
    Start = 1; Op = 2'b00; A = 32'd6; B = 32'd7;
    @(posedge Clk);
    #1 Start = 0;
    repeat (3) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    MdUse_D = 1;
    #1 chk("abort_stall", 32'(Stall), 0);
    Reset = 1; MdUse_D = 0;
    repeat (8) @(negedge Clk);
    chk("abort_late_busy", 32'(Busy), 0);
    chk("abort_late_hi", HI, 0);
    chk("abort_late_lo", LO, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
